// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default flit/VC sizing and width helpers.
package noc_pkg;

  localparam int unsigned FLIT_WIDTH = 8;
  localparam int unsigned DEF_NUM_VC = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(value))) r++;
    return r;
  endfunction

  // A single-VC build still needs a one-bit select field.
  function automatic int unsigned vc_width(input int unsigned num_vc);
    return (num_vc > 1) ? clog2(num_vc) : 1;
  endfunction

  typedef logic [vc_width(DEF_NUM_VC)-1:0] vc_idx_t;

endpackage

// File: rtl/fifo_channel.sv
// One virtual-channel circular queue: storage, pointers, occupancy and registered flags.
module fifo_channel
  import noc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FLIT_WIDTH,
  parameter  int unsigned DEPTH      = 8,
  parameter  int unsigned AF_LEVEL   = 6,
  localparam int unsigned CW         = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CW'(DEPTH));
      almost_full <= (count_nxt >= CW'(AF_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/vc_fifo_buffer.sv
// Multi-VC router input buffer: accept decoding, registered read port and error pulses.
module vc_fifo_buffer
  import noc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FLIT_WIDTH,
  parameter  int unsigned DEPTH      = 8,
  parameter  int unsigned NUM_VC     = DEF_NUM_VC,
  parameter  int unsigned AF_LEVEL   = 6,
  localparam int unsigned VCW        = vc_width(NUM_VC),
  localparam int unsigned CW         = clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    Data_in,
  input  logic                     write,
  input  logic [VCW-1:0]           wr_vc,
  input  logic                     read,
  input  logic [VCW-1:0]           rd_vc,
  output logic [DATA_WIDTH-1:0]    Data_out,
  output logic                     out_valid,
  output logic [VCW-1:0]           out_vc,
  output logic [NUM_VC-1:0]        empty,
  output logic [NUM_VC-1:0]        full,
  output logic [NUM_VC-1:0]        almost_full,
  output logic [NUM_VC*CW-1:0]     count,
  output logic                     overflow,
  output logic                     underflow
);

  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic [NUM_VC-1:0]     rd_hit;
  logic [NUM_VC-1:0]     wr_sel;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  rd_ok_c;
  logic                  wr_ok_c;

  // Out-of-range VC indices match no channel, so they fall out as rejects.
  // A full VC still takes a write when the same VC is popped that edge.
  always_comb begin
    rd_hit    = '0;
    wr_sel    = '0;
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      rd_hit[i] = read && (rd_vc == VCW'(i)) && !empty[i];
      wr_sel[i] = write && (wr_vc == VCW'(i)) && (!full[i] || rd_hit[i]);
      if (rd_hit[i]) rd_data_c = head[i];
    end
  end

  assign rd_ok_c = |rd_hit;
  assign wr_ok_c = |wr_sel;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF_LEVEL)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst),
      .push        (wr_sel[i]),
      .pop         (rd_hit[i]),
      .din         (Data_in),
      .dout        (head[i]),
      .count       (count[i*CW +: CW]),
      .empty       (empty[i]),
      .full        (full[i]),
      .almost_full (almost_full[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Data_out  <= '0;
      out_valid <= 1'b0;
      out_vc    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= rd_ok_c;
      if (rd_ok_c) begin
        Data_out <= rd_data_c;
        out_vc   <= rd_vc;
      end
      overflow  <= write && !wr_ok_c;
      underflow <= read && !rd_ok_c;
    end
  end

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Directed self-checking bench for vc_fifo_buffer (DEPTH=8, NUM_VC=2, AF_LEVEL=6).
module tb_vc_fifo_buffer;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] Data_in = '0;
  logic       write = 1'b0;
  vc_idx_t    wr_vc = '0;
  logic       read = 1'b0;
  vc_idx_t    rd_vc = '0;
  logic [7:0] Data_out;
  logic       out_valid;
  vc_idx_t    out_vc;
  logic [1:0] empty, full, almost_full;
  logic [7:0] count;
  logic       overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  vc_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(8), .NUM_VC(2), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .Data_in(Data_in), .write(write), .wr_vc(wr_vc),
    .read(read), .rd_vc(rd_vc), .Data_out(Data_out), .out_valid(out_valid),
    .out_vc(out_vc), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic push(input int vc, input int d);
    write = 1'b1; wr_vc = vc_idx_t'(vc); Data_in = 8'(d);
    step();
  endtask

  task automatic pop(input int vc);
    read = 1'b1; rd_vc = vc_idx_t'(vc);
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (empty !== 2'b11 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_hold: empty=%b out_valid=%b want 11/0", empty, out_valid);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (empty !== 2'b11 || full !== 2'b00 || almost_full !== 2'b00 || count !== 8'h00) begin
      miscompares++; $display("FAIL reset_flags: empty=%b full=%b af=%b count=%h want 11/00/00/00",
                              empty, full, almost_full, count);
    end
    vectors++;
    if (out_valid !== 1'b0 || Data_out !== 8'h00 || out_vc !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_out: valid=%b data=%h vc=%b ovf=%b udf=%b want 0/00/0/0/0",
                              out_valid, Data_out, out_vc, overflow, underflow);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      push(0, i);
      vectors++;
      if (count[3:0] !== 4'(i) || almost_full[0] !== (i >= 6) || full[0] !== (i == 8) || overflow !== 1'b0) begin
        miscompares++; $display("FAIL fill_%0d: count0=%0d af0=%b full0=%b ovf=%b want %0d/%b/%b/0",
                                i, count[3:0], almost_full[0], full[0], overflow, i, i >= 6, i == 8);
      end
    end
    push(0, 9);
    vectors++;
    if (overflow !== 1'b1 || count[3:0] !== 4'd8 || full[0] !== 1'b1 || empty[1] !== 1'b1 || count[7:4] !== 4'd0) begin
      miscompares++; $display("FAIL overflow: ovf=%b count0=%0d full0=%b empty1=%b count1=%0d want 1/8/1/1/0",
                              overflow, count[3:0], full[0], empty[1], count[7:4]);
    end
    step();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("FAIL overflow_pulse: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 8; i++) begin
      pop(0);
      vectors++;
      if (out_valid !== 1'b1 || Data_out !== 8'(i) || out_vc !== 1'b0 || underflow !== 1'b0 || count[3:0] !== 4'(8 - i)) begin
        miscompares++; $display("FAIL drain_%0d: valid=%b data=%h vc=%b udf=%b count0=%0d want 1/%h/0/0/%0d",
                                i, out_valid, Data_out, out_vc, underflow, count[3:0], 8'(i), 8 - i);
      end
    end
    pop(0);
    vectors++;
    if (underflow !== 1'b1 || out_valid !== 1'b0 || Data_out !== 8'd8 || empty[0] !== 1'b1) begin
      miscompares++; $display("FAIL underflow: udf=%b valid=%b data=%h empty0=%b want 1/0/08/1",
                              underflow, out_valid, Data_out, empty[0]);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [8];
    for (int i = 1; i <= 8; i++) push(0, i);
    write = 1'b1; wr_vc = 1'b0; Data_in = 8'd20;
    read  = 1'b1; rd_vc = 1'b0;
    step();
    vectors++;
    if (overflow !== 1'b0 || count[3:0] !== 4'd8 || full[0] !== 1'b1 || out_valid !== 1'b1 || Data_out !== 8'd1) begin
      miscompares++; $display("FAIL full_rw: ovf=%b count0=%0d full0=%b valid=%b data=%h want 0/8/1/1/01",
                              overflow, count[3:0], full[0], out_valid, Data_out);
    end
    exp_q = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd20};
    for (int i = 0; i < 8; i++) begin
      pop(0);
      vectors++;
      if (Data_out !== exp_q[i] || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL full_rw_drain_%0d: data=%h valid=%b want %h/1", i, Data_out, out_valid, exp_q[i]);
      end
    end
    // empty VC read + write to the same VC: write only, no bypass
    write = 1'b1; wr_vc = 1'b1; Data_in = 8'h55;
    read  = 1'b1; rd_vc = 1'b1;
    step();
    vectors++;
    if (underflow !== 1'b1 || out_valid !== 1'b0 || count[7:4] !== 4'd1 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL empty_rw: udf=%b valid=%b count1=%0d ovf=%b want 1/0/1/0",
                              underflow, out_valid, count[7:4], overflow);
    end
    pop(1);
    vectors++;
    if (Data_out !== 8'h55 || out_vc !== 1'b1 || out_valid !== 1'b1 || empty[1] !== 1'b1) begin
      miscompares++; $display("FAIL empty_rw_pop: data=%h vc=%b valid=%b empty1=%b want 55/1/1/1",
                              Data_out, out_vc, out_valid, empty[1]);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 3; i++) begin
      push(0, 8'hA0 + i);
      push(1, 8'hB0 + i);
    end
    vectors++;
    if (count !== 8'h33) begin
      miscompares++; $display("FAIL interleave_count: count=%h want 33", count);
    end
    for (int i = 0; i < 3; i++) begin
      pop(0);
      vectors++;
      if (Data_out !== 8'(8'hA0 + i) || out_vc !== 1'b0 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL interleave_vc0_%0d: data=%h vc=%b valid=%b want %h/0/1",
                                i, Data_out, out_vc, out_valid, 8'(8'hA0 + i));
      end
      pop(1);
      vectors++;
      if (Data_out !== 8'(8'hB0 + i) || out_vc !== 1'b1 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL interleave_vc1_%0d: data=%h vc=%b valid=%b want %h/1/1",
                                i, Data_out, out_vc, out_valid, 8'(8'hB0 + i));
      end
    end
    // simultaneous read and write of different VCs
    push(0, 8'h11);
    write = 1'b1; wr_vc = 1'b1; Data_in = 8'h22;
    read  = 1'b1; rd_vc = 1'b0;
    step();
    vectors++;
    if (Data_out !== 8'h11 || out_vc !== 1'b0 || count !== 8'h10) begin
      miscompares++; $display("FAIL cross_rw: data=%h vc=%b count=%h want 11/0/10", Data_out, out_vc, count);
    end
    pop(1);
    vectors++;
    if (Data_out !== 8'h22 || out_vc !== 1'b1 || empty !== 2'b11) begin
      miscompares++; $display("FAIL cross_rw_pop: data=%h vc=%b empty=%b want 22/1/11", Data_out, out_vc, empty);
    end
  endtask

  task automatic test_wrap_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 8; k++) push(0, c * 16 + k);
      for (int k = 0; k < 8; k++) begin
        pop(0);
        vectors++;
        if (Data_out !== 8'(c * 16 + k)) begin
          miscompares++; $display("FAIL wrap_c%0d_k%0d: data=%h want %h", c, k, Data_out, 8'(c * 16 + k));
        end
      end
    end
    for (int k = 0; k < 6; k++) push(0, 8'h70 + k);
    pop(0);
    vectors++;
    if (count[3:0] !== 4'd5 || Data_out !== 8'h70 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL prereset: count0=%0d data=%h valid=%b want 5/70/1", count[3:0], Data_out, out_valid);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (empty !== 2'b11 || count !== 8'h00 || out_valid !== 1'b0 || Data_out !== 8'h00 || almost_full !== 2'b00) begin
      miscompares++; $display("FAIL async_reset: empty=%b count=%h valid=%b data=%h af=%b want 11/00/0/00/00",
                              empty, count, out_valid, Data_out, almost_full);
    end
    #2 rst = 1'b1;
    push(0, 8'h31);
    push(0, 8'h32);
    pop(0);
    vectors++;
    if (Data_out !== 8'h31 || count[3:0] !== 4'd1) begin
      miscompares++; $display("FAIL post_reset_0: data=%h count0=%0d want 31/1", Data_out, count[3:0]);
    end
    pop(0);
    vectors++;
    if (Data_out !== 8'h32 || empty[0] !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_1: data=%h empty0=%b want 32/1", Data_out, empty[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_rw();
    test_interleave();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
